imm_gen_stage: RTL

//  Pipelined immediate generator for the decode stage. Accepts an instruction word plus a format

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_format_mux.sv | 39 +++
 rtl/imm_gen_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: format-select codes and legality check.
// IMM_ZICSR_EN (optional macro) makes the Z (CSR uimm) format legal.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  function automatic logic imm_legal(input logic [2:0] src);
`ifdef IMM_ZICSR_EN
    return (src <= IMM_Z);
`else
    return (src <= IMM_U);
`endif
  endfunction

endpackage

// File: rtl/imm_format_mux.sv
// Combinational immediate extraction for I/S/B/J/U (and Z when IMM_ZICSR_EN is defined).
// Every format is first built as a signed 32-bit value, then sign-extended to XLEN.
module imm_format_mux
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic signed [31:0] raw;
  logic               unused_opcode;

  // The opcode field never contributes to an immediate.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw = '0;
    case (src)
      IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: raw = {instr[31:12], 12'b0};
`ifdef IMM_ZICSR_EN
      IMM_Z: raw = {27'b0, instr[19:15]};
`endif
      default: raw = '0;
    endcase
  end

  // Size cast of a signed operand replicates bit 31 into the upper XLEN-32 bits.
  assign imm = XLEN'(raw);
  assign err = !imm_legal(src);

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: format mux feeding a 2-entry skid buffer (main M + skid K).
// Optional feature: IMM_ZICSR_EN enables the Z (CSR uimm) format in the mux.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [XLEN-1:0]  imm_p0;
  logic             err_p0;

  logic             vld_p1;
  logic             k_vld_p1;
  logic [XLEN-1:0]  m_imm_p1;
  logic [TAG_W-1:0] m_tag_p1;
  logic             m_err_p1;
  logic [XLEN-1:0]  k_imm_p1;
  logic [TAG_W-1:0] k_tag_p1;
  logic             k_err_p1;

  logic [1:0]       state;
  logic             in_fire;
  logic             load_m_in;
  logic             load_m_k;
  logic             load_k;
  logic             vld_next;
  logic             k_vld_next;

  // Stage p0: immediate formed combinationally from the offered beat.
  imm_format_mux #(
    .XLEN(XLEN)
  ) u_format_mux (
    .instr(in_instr),
    .src  (in_src),
    .imm  (imm_p0),
    .err  (err_p0)
  );

  assign state     = {vld_p1, k_vld_p1};
  assign in_ready  = !k_vld_p1;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_p1;
  assign out_imm   = m_imm_p1;
  assign out_tag   = m_tag_p1;
  assign out_err   = m_err_p1;

  always_comb begin
    load_m_in  = 1'b0;
    load_m_k   = 1'b0;
    load_k     = 1'b0;
    vld_next   = vld_p1;
    k_vld_next = k_vld_p1;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_m_in = 1'b1;
          vld_next  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_ready) begin
          load_m_in = 1'b1;
        end else if (in_fire) begin
          load_k     = 1'b1;
          k_vld_next = 1'b1;
        end else if (out_ready) begin
          vld_next = 1'b0;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          load_m_k   = 1'b1;
          k_vld_next = 1'b0;
        end
      end
      default: begin
        vld_next   = 1'b0;
        k_vld_next = 1'b0;
      end
    endcase
  end

  // Stage p1: main register drives the outputs; it only reloads when empty or draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      k_vld_p1 <= 1'b0;
      m_imm_p1 <= '0;
      m_tag_p1 <= '0;
      m_err_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      k_vld_p1 <= 1'b0;
    end else begin
      vld_p1   <= vld_next;
      k_vld_p1 <= k_vld_next;
      if (load_m_in) begin
        m_imm_p1 <= imm_p0;
        m_tag_p1 <= in_tag;
        m_err_p1 <= err_p0;
      end else if (load_m_k) begin
        m_imm_p1 <= k_imm_p1;
        m_tag_p1 <= k_tag_p1;
        m_err_p1 <= k_err_p1;
      end
    end
  end

  // Skid data is qualified by k_vld_p1, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_k) begin
      k_imm_p1 <= imm_p0;
      k_tag_p1 <= in_tag;
      k_err_p1 <= err_p0;
    end
  end

endmodule
